// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_pkg;

   localparam int unsigned TT_IN_W = 3;
   localparam int unsigned TT_W    = 8;

   // Reference truth tables, indexed by gate function
   localparam logic [TT_W-1:0] TT_0x7E = 8'h7E;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input gate through all input combinations, samples its output
// after a settle window and reports the captured truth table.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int unsigned      SETTLE_CYCLES = 4,
   parameter logic [TT_W-1:0]  EXPECTED      = TT_0x7E
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               dut_out,
   output logic [TT_IN_W-1:0] pattern,
   output logic               busy,
   output logic               done,
   output logic [TT_W-1:0]    truth_table,
   output logic               match
);

   localparam int unsigned        CNT_W    = 8;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [TT_IN_W-1:0] PAT_LAST = TT_IN_W'((1 << TT_IN_W) - 1);

   // Settle window must cover the synchroniser latency plus one cycle of gate delay
   if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $fatal(1, "truth_table_sweeper: SETTLE_CYCLES must be within 3..255");
   end

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [TT_IN_W-1:0]   pattern_n;
   logic                 busy_n, done_n, match_n;
   logic [TT_W-1:0]      tt_n, tt_sampled;
   logic                 dut_sync;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (dut_out),
      .q     (dut_sync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         pattern     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         truth_table <= '0;
         match       <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         pattern     <= pattern_n;
         busy        <= busy_n;
         done        <= done_n;
         truth_table <= tt_n;
         match       <= match_n;
      end
   end

   // Next-state and next-output logic; pattern only moves on a count wrap
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      pattern_n  = pattern;
      busy_n     = busy;
      done_n     = 1'b0;
      tt_n       = truth_table;
      match_n    = match;
      tt_sampled = truth_table;
      tt_sampled[pattern] = dut_sync;

      case (state)
         IDLE: begin
            if (start) begin
               pattern_n = '0;
               cnt_n     = '0;
               tt_n      = '0;
               match_n   = 1'b0;
               busy_n    = 1'b1;
               state_n   = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == CNT_LAST) begin
               tt_n = tt_sampled;
               if (pattern == PAT_LAST) begin
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  match_n = (tt_sampled == EXPECTED);
                  state_n = FINISH;
               end else begin
                  pattern_n = pattern + TT_IN_W'(1);
                  cnt_n     = '0;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper with behavioural gate models.
module tb_truth_table_sweeper;
   import tt_pkg::*;

   typedef struct packed {
      logic [7:0] tt;
      logic       m;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start4, start3;
   logic [1:0] mode4;
   logic       mode3;
   logic       dut_out4, dut_out3;

   logic [2:0] pattern4, pattern3;
   logic       busy4, busy3, done4, done3, match4, match3;
   logic [7:0] tt4, tt3;

   wire        d8, d25;

   int   n_pass = 0;
   int   n_total = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic gate_7e(input logic [2:0] p);
      return ~(&p) & (|p);
   endfunction

   // Gate models: instantaneous/constant for the default instance, delayed for the fast one
   assign #8  d8  = gate_7e(pattern3);
   assign #25 d25 = gate_7e(pattern3);

   always_comb begin
      case (mode4)
         2'd1:    dut_out4 = 1'b0;
         2'd2:    dut_out4 = 1'b1;
         default: dut_out4 = gate_7e(pattern4);
      endcase
      dut_out3 = mode3 ? d25 : d8;
   end

   truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(TT_0x7E)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .dut_out(dut_out4),
      .pattern(pattern4), .busy(busy4), .done(done4),
      .truth_table(tt4), .match(match4)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(TT_0x7E)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .dut_out(dut_out3),
      .pattern(pattern3), .busy(busy3), .done(done3),
      .truth_table(tt3), .match(match3)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_sweep(input bit use3, output int cyc);
      cyc = -1;
      @(posedge clk); #1;
      if (use3) start3 = 1'b1; else start4 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      start4 = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if ((use3 ? done3 : done4) === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start4 = 1'b0; start3 = 1'b0; mode4 = 2'd0; mode3 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (pattern4 !== 3'd0) $display("FAIL reset_pattern got %0d exp 0", pattern4); else n_pass++;
      n_total++; if (busy4 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy4); else n_pass++;
      n_total++; if (done4 !== 1'b0) $display("FAIL reset_done got %b exp 0", done4); else n_pass++;
      n_total++; if (tt4 !== 8'h00) $display("FAIL reset_tt got %h exp 00", tt4); else n_pass++;
      n_total++; if (match4 !== 1'b0) $display("FAIL reset_match got %b exp 0", match4); else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_sweep_7e();
      exp_t e;
      mode4 = 2'd0;
      sb.push_back('{tt: 8'h7E, m: 1'b1});
      @(posedge clk); #1; start4 = 1'b1;
      @(posedge clk); #1; start4 = 1'b0;
      for (int k = 0; k < 32; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         n_total++;
         if (pattern4 !== 3'(k / 4) || busy4 !== 1'b1 || done4 !== 1'b0)
            $display("FAIL sweep_step%0d got pat=%0d busy=%b done=%b exp pat=%0d busy=1 done=0",
                     k, pattern4, busy4, done4, k / 4);
         else n_pass++;
      end
      @(posedge clk); #1;
      n_total++;
      if (done4 !== 1'b1 || busy4 !== 1'b0 || pattern4 !== 3'd7)
         $display("FAIL sweep_done32 got done=%b busy=%b pat=%0d exp done=1 busy=0 pat=7", done4, busy4, pattern4);
      else n_pass++;
      if (sb.size() == 0) begin
         n_total++; $display("FAIL sweep_sb got empty queue exp one entry");
      end else begin
         e = sb.pop_front();
         n_total++; if (tt4 !== e.tt) $display("FAIL sweep_tt got %h exp %h", tt4, e.tt); else n_pass++;
         n_total++; if (match4 !== e.m) $display("FAIL sweep_match got %b exp %b", match4, e.m); else n_pass++;
      end
      @(posedge clk); #1;
      n_total++; if (done4 !== 1'b0) $display("FAIL sweep_done_pulse got %b exp 0", done4); else n_pass++;
      repeat (5) @(posedge clk);
      #1;
      n_total++;
      if (tt4 !== e.tt || match4 !== e.m || busy4 !== 1'b0)
         $display("FAIL sweep_hold got tt=%h m=%b busy=%b exp tt=%h m=%b busy=0", tt4, match4, busy4, e.tt, e.m);
      else n_pass++;
   endtask

   task automatic test_const();
      exp_t e;
      int   cyc;
      for (int v = 1; v <= 2; v++) begin
         mode4 = 2'(v);
         sb.push_back('{tt: (v == 1) ? 8'h00 : 8'hFF, m: 1'b0});
         run_sweep(1'b0, cyc);
         n_total++; if (cyc != 32) $display("FAIL const%0d_latency got %0d exp 32", v, cyc); else n_pass++;
         e = sb.pop_front();
         n_total++; if (tt4 !== e.tt) $display("FAIL const%0d_tt got %h exp %h", v, tt4, e.tt); else n_pass++;
         n_total++; if (match4 !== e.m) $display("FAIL const%0d_match got %b exp %b", v, match4, e.m); else n_pass++;
         repeat (3) @(posedge clk);
      end
      mode4 = 2'd0;
   endtask

   task automatic test_settle3();
      exp_t       e;
      int         cyc;
      logic [7:0] stale;
      mode3 = 1'b0;
      sb.push_back('{tt: 8'h7E, m: 1'b1});
      run_sweep(1'b1, cyc);
      n_total++; if (cyc != 24) $display("FAIL s3_fast_latency got %0d exp 24", cyc); else n_pass++;
      e = sb.pop_front();
      n_total++; if (tt3 !== e.tt) $display("FAIL s3_fast_tt got %h exp %h", tt3, e.tt); else n_pass++;
      n_total++; if (match3 !== e.m) $display("FAIL s3_fast_match got %b exp %b", match3, e.m); else n_pass++;
      repeat (4) @(posedge clk);
      // Slow gate: each sample still sees the previous pattern (pattern sits at 7 before the sweep)
      for (int i = 0; i < 8; i++) stale[i] = gate_7e((i == 0) ? 3'd7 : 3'(i - 1));
      mode3 = 1'b1;
      sb.push_back('{tt: stale, m: (stale == 8'h7E)});
      run_sweep(1'b1, cyc);
      e = sb.pop_front();
      n_total++; if (tt3 !== e.tt) $display("FAIL s3_slow_tt got %h exp %h", tt3, e.tt); else n_pass++;
      n_total++; if (match3 !== e.m) $display("FAIL s3_slow_match got %b exp %b", match3, e.m); else n_pass++;
      mode3 = 1'b0;
   endtask

   task automatic test_start_ignored();
      exp_t e;
      int   ndone = 0;
      int   kdone = -1;
      sb.push_back('{tt: 8'h7E, m: 1'b1});
      @(posedge clk); #1; start4 = 1'b1;
      @(posedge clk); #1; start4 = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk); #1;
         if (done4 === 1'b1) begin
            ndone++;
            kdone = k;
            if (sb.size() != 0) begin
               e = sb.pop_front();
               n_total++; if (tt4 !== e.tt) $display("FAIL ign_tt got %h exp %h", tt4, e.tt); else n_pass++;
            end else begin
               n_total++; $display("FAIL ign_sb got extra done exp none");
            end
         end
         start4 = (k == 5 || k == 20 || k == 32);
      end
      start4 = 1'b0;
      n_total++; if (ndone != 1) $display("FAIL ign_done_count got %0d exp 1", ndone); else n_pass++;
      n_total++; if (kdone != 32) $display("FAIL ign_done_cycle got %0d exp 32", kdone); else n_pass++;
      n_total++; if (busy4 !== 1'b0) $display("FAIL ign_busy_after got %b exp 0", busy4); else n_pass++;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   ndone = 0;
      int   cyc;
      @(posedge clk); #1; start4 = 1'b1;
      @(posedge clk); #1; start4 = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      n_total++; if (pattern4 !== 3'd3) $display("FAIL rmid_pre_pattern got %0d exp 3", pattern4); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (pattern4 !== 3'd0 || busy4 !== 1'b0 || tt4 !== 8'h00 || match4 !== 1'b0 || done4 !== 1'b0)
         $display("FAIL rmid_async got pat=%0d busy=%b tt=%h m=%b done=%b exp all 0",
                  pattern4, busy4, tt4, match4, done4);
      else n_pass++;
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done4 === 1'b1 || busy4 === 1'b1) ndone++;
      end
      n_total++; if (ndone != 0) $display("FAIL rmid_idle got %0d active cycles exp 0", ndone); else n_pass++;
      sb.push_back('{tt: 8'h7E, m: 1'b1});
      run_sweep(1'b0, cyc);
      n_total++; if (cyc != 32) $display("FAIL rmid_latency got %0d exp 32", cyc); else n_pass++;
      e = sb.pop_front();
      n_total++; if (tt4 !== e.tt) $display("FAIL rmid_tt got %h exp %h", tt4, e.tt); else n_pass++;
      n_total++; if (match4 !== e.m) $display("FAIL rmid_match got %b exp %b", match4, e.m); else n_pass++;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_start_held();
      exp_t e;
      int   ndone = 0;
      int   kd[$];
      sb.push_back('{tt: 8'h7E, m: 1'b1});
      sb.push_back('{tt: 8'h7E, m: 1'b1});
      @(posedge clk); #1; start4 = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 110; k++) begin
         @(posedge clk); #1;
         if (k == 40) start4 = 1'b0;
         if (k == 34) begin
            n_total++;
            if (busy4 !== 1'b1 || tt4 !== 8'h00 || pattern4 !== 3'd0)
               $display("FAIL held_restart got busy=%b tt=%h pat=%0d exp busy=1 tt=00 pat=0",
                        busy4, tt4, pattern4);
            else n_pass++;
         end
         if (done4 === 1'b1) begin
            ndone++;
            kd.push_back(k);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               n_total++; if (tt4 !== e.tt || match4 !== e.m)
                  $display("FAIL held_result%0d got tt=%h m=%b exp tt=%h m=%b", ndone, tt4, match4, e.tt, e.m);
               else n_pass++;
            end else begin
               n_total++; $display("FAIL held_sb got extra done at cycle %0d exp none", k);
            end
         end
      end
      start4 = 1'b0;
      n_total++; if (ndone != 2) $display("FAIL held_done_count got %0d exp 2", ndone); else n_pass++;
      if (kd.size() == 2) begin
         n_total++;
         if (kd[0] != 32 || kd[1] != 66)
            $display("FAIL held_done_cycles got %0d,%0d exp 32,66", kd[0], kd[1]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_sweep_7e();
      test_const();
      test_settle3();
      test_start_ignored();
      test_reset_mid();
      test_start_held();
      n_total++; if (sb.size() != 0) $display("FAIL sb_drain got %0d left exp 0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Characterisation stage wrapped around a 3-input combinational logic gate (e.g. the 0x7E function).
- Upstream side: drives the gate's inputs {in1,in2,in3} through all 8 combinations, 3'b000 to 3'b111.
- Downstream side: waits a programmable settle time per combination, samples the gate's output, and assembles an 8-bit truth-table word.
- Bit i of the word holds the gate output for input combination i; the word is compared against an expected value, so a correct 0x7E gate reports 8'h7E.

Parameters:
- SETTLE_CYCLES, 4: cycles each pattern is held before sampling; legal range 3..255.
- EXPECTED, 8'h7E: reference truth table used to compute match.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a sweep; honoured only in IDLE.
- dut_out  input  1  output of the gate under test; may be asynchronous to clk.
- pattern  output  3  drives {in1,in2,in3}; registered.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when the sweep completes.
- truth_table  output  8  captured word; bit i = sampled dut_out for pattern i.
- match  output  1  truth_table == EXPECTED; valid from done onward.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; pattern=0, busy=0, done=0, truth_table=0, match=0.
  - Counter and synchroniser flops cleared.
- Input path: dut_out passes through a 2-flop synchroniser (dut_sync), giving 2 cycles of latency. The SETTLE_CYCLES>=3 lower bound covers this.
- FSM states: IDLE, SETTLE, FINISH.
- IDLE, start=1 at edge E0:
  - pattern<=0, cnt<=0, truth_table<=0, match<=0, busy<=1; state<=SETTLE.
  - start=0: hold all outputs, including the last truth_table and match.
- SETTLE, cnt != SETTLE_CYCLES-1: cnt<=cnt+1.
- SETTLE, cnt == SETTLE_CYCLES-1:
  - truth_table[pattern]<=dut_sync.
  - pattern==7: busy<=0, done<=1, match<=(next truth_table value == EXPECTED); state<=FINISH. pattern stays at 7.
  - Otherwise: pattern<=pattern+1, cnt<=0.
- FINISH: done<=0; state<=IDLE. FINISH lasts exactly one cycle.
- Timing:
  - Each pattern is held for exactly SETTLE_CYCLES cycles.
  - done is high during the cycle following edge E0+8*SETTLE_CYCLES (33rd cycle after the start edge for the default of 4).
- Status signals:
  - busy and done are never high together.
  - truth_table and match stay stable from done until the next accepted start.
- start is ignored in SETTLE and FINISH; it is not queued.
- start held high continuously: a new sweep begins on the first IDLE cycle after FINISH.
- pattern changes only at a SETTLE count wrap, so it is glitch-free toward the gate.
- Reset mid-sweep: immediate return to reset values; no partial done pulse. The next sweep needs a fresh start.
- Parameter outside 3..255: elaboration-time fatal error.

Decomposition:
- Shared package tt_pkg:
  - state enum {IDLE, SETTLE, FINISH}.
  - TT_IN_W=3, TT_W=8.
  - Default EXPECTED constant per gate function (TT_0x7E = 8'h7E).
- One sub-module: sync_2ff (1-bit, async active-low reset, reset value 0) for dut_out.

Test Plan:
- Behavioural 0x7E model (out = !(in1&in2&in3) & (in1|in2|in3)), SETTLE_CYCLES=4, pulse start → pattern steps 0..7 with 4 cycles each; done 33 cycles after the start edge; truth_table=8'h7E; match=1.
- Model tied to 0 → truth_table=8'h00, match=0. Tied to 1 → 8'hFF, match=0.
- Model with 1-cycle combinational delay, SETTLE_CYCLES=3 → truth_table=8'h7E (synchroniser plus delay fit within the settle window). A 3-cycle delay model gives a corrupted word and match=0.
- start pulsed at cycles 5 and 20 of a sweep, and during FINISH → single sweep; done pulses exactly once.
- rst_n low mid-sweep (pattern=3) → pattern, busy, truth_table, match all 0 immediately; no done. A subsequent start completes normally with 8'h7E.
- start held high across two sweeps → second sweep begins the cycle after FINISH; truth_table cleared at its start; done pulses once per sweep.
